// File: rtl/riscv_pkg.sv
// Shared RV32 definitions for the front-end pipeline stages.
// Reset vector, canonical NOP and opcode map used by fetch and decode.
package riscv_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h4000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } inst_fmt_e;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, reads the sync IMEM and hands
// {inst, pc} to decode over valid/ready with a one-entry hold buffer.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int                W_SIZE   = 32,
    parameter logic [W_SIZE-1:0] RESET_PC = W_SIZE'(DEFAULT_RESET_PC),
    parameter int                IMEM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [W_SIZE-1:0]  imem_dout,
    input  logic               redirect_valid,
    input  logic [W_SIZE-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W_SIZE-1:0]  inst_out,
    output logic [W_SIZE-1:0]  pc_out
);

    logic [W_SIZE-1:0] pc_f;
    logic [W_SIZE-1:0] req_pc;
    logic              req_pend;
    logic              hold_valid;
    logic [W_SIZE-1:0] hold_inst;
    logic [W_SIZE-1:0] hold_pc;

    logic              fire;
    logic              hold_valid_next;
    logic              hold_load;
    logic [W_SIZE-1:0] redirect_base;
    logic [W_SIZE-1:0] sel_inst;
    logic [W_SIZE-1:0] sel_pc;
    logic              unused_redirect_lsbs;

    assign redirect_base        = {redirect_pc[W_SIZE-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign sel_inst  = hold_valid ? hold_inst : imem_dout;
    assign sel_pc    = hold_valid ? hold_pc : req_pc;
    assign out_valid = (hold_valid | req_pend) & ~redirect_valid;
    assign fire      = out_valid & out_ready;
    assign inst_out  = out_valid ? sel_inst : W_SIZE'(NOP_INST);
    assign pc_out    = sel_pc;

    assign imem_en   = redirect_valid | ~hold_valid_next;
    assign imem_addr = redirect_valid ? redirect_pc[IMEM_AW+1:2]
                                      : pc_f[IMEM_AW+1:2];

    // Decide whether the hold slot is occupied next cycle and what fills it.
    always_comb begin
        hold_valid_next = 1'b0;
        hold_load       = 1'b0;
        if (redirect_valid) begin
            hold_valid_next = 1'b0;
        end else if (hold_valid) begin
            hold_valid_next = fire ? req_pend : 1'b1;
            hold_load       = fire & req_pend;
        end else begin
            hold_valid_next = req_pend & ~out_ready;
            hold_load       = req_pend & ~out_ready;
        end
    end

    // PC, in-flight read tracking and hold register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f       <= RESET_PC;
            req_pend   <= 1'b0;
            req_pc     <= '0;
            hold_valid <= 1'b0;
            hold_inst  <= '0;
            hold_pc    <= '0;
        end else begin
            hold_valid <= hold_valid_next;
            if (hold_load) begin
                hold_inst <= imem_dout;
                hold_pc   <= req_pc;
            end
            if (redirect_valid) begin
                req_pend <= 1'b1;
                req_pc   <= redirect_base;
                pc_f     <= redirect_base + W_SIZE'(4);
            end else if (imem_en) begin
                req_pend <= 1'b1;
                req_pc   <= pc_f;
                pc_f     <= pc_f + W_SIZE'(4);
            end else begin
                req_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vectors plus random
// back-pressure/redirect/reset against an in-order PC-stream model.
module tb_fetch_stage;
    import riscv_pkg::*;

    localparam int          W   = 32;
    localparam int          AW  = 14;
    localparam logic [31:0] RPC = 32'h4000_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [W-1:0]  imem_dout;
    logic          redirect_valid;
    logic [W-1:0]  redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  inst_out;
    logic [W-1:0]  pc_out;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_pc;
    logic [31:0] issue_pc;
    int          outstanding;

    typedef struct {
        logic [31:0] tgt;
        int          stall;
        logic [31:0] pc0;
        logic [31:0] pc1;
    } vec_t;

    vec_t tv[5];
    logic en_seen[5];

    always #5 clk = ~clk;

    fetch_stage #(
        .W_SIZE  (W),
        .RESET_PC(RPC),
        .IMEM_AW (AW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_dout     (imem_dout),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .inst_out      (inst_out),
        .pc_out        (pc_out)
    );

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return {a, 2'b11, ~a, 2'b01} ^ 32'hA5C3_0F00;
    endfunction

    function automatic logic [AW-1:0] wa(input logic [31:0] p);
        return p[AW+1:2];
    endfunction

    // Synchronous-read IMEM; output is garbage on cycles with no read.
    always @(posedge clk)
        imem_dout <= imem_en ? mem_word(imem_addr) : W'($urandom());

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Check outputs for the inputs just applied, advance the model,
    // then move to the next falling edge.
    task automatic cycle();
        logic [31:0] tgt;
        #1;
        if (!rst_n) begin
            chk("rst_valid", 32'(out_valid), 0);
            chk("rst_nop", inst_out, NOP_INST);
            exp_pc      = RPC;
            issue_pc    = RPC;
            outstanding = 0;
        end else if (redirect_valid) begin
            tgt = {redirect_pc[31:2], 2'b00};
            chk("redir_valid", 32'(out_valid), 0);
            chk("redir_en", 32'(imem_en), 1);
            chk("redir_addr", 32'(imem_addr), 32'(wa(tgt)));
            exp_pc      = tgt;
            issue_pc    = tgt + 32'd4;
            outstanding = 1;
        end else begin
            chk("valid", 32'(out_valid), 32'(outstanding > 0));
            if (!out_valid) chk("idle_nop", inst_out, NOP_INST);
            if (out_ready) chk("ready_en", 32'(imem_en), 1);
            if (out_valid && out_ready) begin
                chk("pc_order", pc_out, exp_pc);
                chk("inst_data", inst_out, mem_word(wa(exp_pc)));
                exp_pc = exp_pc + 32'd4;
                outstanding--;
            end
            if (imem_en) begin
                chk("issue_addr", 32'(imem_addr), 32'(wa(issue_pc)));
                issue_pc = issue_pc + 32'd4;
                outstanding++;
            end
            chk("outstanding", 32'(outstanding <= 2), 1);
        end
        @(negedge clk);
    endtask

    initial begin
        tv[0] = '{32'h4000_0102, 2, 32'h4000_0100, 32'h4000_0104};
        tv[1] = '{32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 32'h0000_0000};
        tv[2] = '{32'h0000_0003, 1, 32'h0000_0000, 32'h0000_0004};
        tv[3] = '{32'h1234_5678, 0, 32'h1234_5678, 32'h1234_567C};
        tv[4] = '{32'h8000_0006, 3, 32'h8000_0004, 32'h8000_0008};

        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        exp_pc         = RPC;
        issue_pc       = RPC;
        outstanding    = 0;

        @(negedge clk);
        cycle();
        cycle();

        // Reset release: first read at RESET_PC, output one cycle later.
        rst_n = 1'b1;
        #1;
        chk("t1_valid0", 32'(out_valid), 0);
        chk("t1_en", 32'(imem_en), 1);
        chk("t1_addr", 32'(imem_addr), 32'(wa(RPC)));
        cycle();
        #1;
        chk("t1_valid1", 32'(out_valid), 1);
        chk("t1_pc0", pc_out, RPC);
        cycle();
        for (int i = 0; i < 4; i++) cycle();

        // Back-pressure for 5 cycles mid-stream.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            en_seen[i] = imem_en;
            cycle();
        end
        for (int i = 1; i < 5; i++)
            chk("t2_en_low", 32'(en_seen[i]), 0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) cycle();

        // Redirect vectors, some taken while the hold slot is full.
        foreach (tv[k]) begin
            out_ready = 1'b0;
            for (int i = 0; i < tv[k].stall; i++) cycle();
            out_ready      = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = tv[k].tgt;
            cycle();
            redirect_valid = 1'b0;
            redirect_pc    = $urandom();
            #1;
            chk("vec_valid", 32'(out_valid), 1);
            chk("vec_pc0", pc_out, tv[k].pc0);
            chk("vec_inst0", inst_out, mem_word(wa(tv[k].pc0)));
            cycle();
            #1;
            chk("vec_pc1", pc_out, tv[k].pc1);
            cycle();
        end

        // Async reset with the hold slot full.
        out_ready = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        chk("t6_valid", 32'(out_valid), 0);
        chk("t6_nop", inst_out, NOP_INST);
        cycle();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("t6_addr", 32'(imem_addr), 32'(wa(RPC)));
        cycle();
        #1;
        chk("t6_pc", pc_out, RPC);
        cycle();

        // Random back-pressure, redirects and occasional resets.
        for (int n = 0; n < 1500; n++) begin
            rst_n          = !($urandom_range(0, 299) == 0);
            out_ready      = ($urandom_range(0, 9) < 7);
            redirect_valid = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
            else
                redirect_pc = $urandom();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
